// File: rtl/inner_product_pkg.sv
// Shared types and width helpers for the sequential inner-product engine.
// Optional product pipeline stage is selected with INNER_PRODUCT_PIPE_EN.
package inner_product_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Element counter width; a single-element vector still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sum of n full-width w x w products can never exceed this many bits.
    function automatic int result_width(input int w, input int n);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/radix4_booth_mult.sv
// Combinational signed W x W -> 2W multiplier using radix-4 Booth recoding.
// W must be even so the top Booth digit lands on the sign bit of b.
module radix4_booth_mult #(
    parameter int W = 8
) (
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);

    logic signed [2*W-1:0] a_ext;
    logic        [W:0]     b_ext;

    assign a_ext = (2*W)'(a);
    assign b_ext = {b, 1'b0};

    // Booth digit {-2,-1,0,+1,+2} selected by overlapping bit triplets of b.
    function automatic logic signed [2*W-1:0] booth_pp(
        input logic [2:0]            grp,
        input logic signed [2*W-1:0] m
    );
        case (grp)
            3'b001, 3'b010: return m;
            3'b011:         return m <<< 1;
            3'b100:         return -(m <<< 1);
            3'b101, 3'b110: return -m;
            default:        return '0;
        endcase
    endfunction

    // NOTE: blocking '=' is correct here -- each loop pass must see the running sum of the previous pass.
    always_comb begin
        p = '0;
        for (int i = 0; i < W / 2; i++) begin
            p = p + (booth_pp(b_ext[2*i +: 3], a_ext) <<< (2 * i));
        end
    end

endmodule

// File: rtl/inner_product_seq.sv
// Sequential N-element signed dot product, one Booth multiply per cycle, valid/ready on both sides.
// Define INNER_PRODUCT_PIPE_EN to register the product and add a DRAIN state (latency N+1).
module inner_product_seq
    import inner_product_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N*W-1:0]                        a,
    input  logic [N*W-1:0]                        b,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [result_width(W, N)-1:0]  p,
    output logic                                  busy
);

    localparam int PW = result_width(W, N);
    localparam int CW = clog2_min1(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t                state, state_next;
    logic [CW-1:0]         cnt;
    logic                  last;
    logic [N*W-1:0]        a_reg, b_reg;
    logic signed [2*W-1:0] prod;
    logic signed [PW-1:0]  prod_ext, acc, acc_sum;

    assign last = (cnt == LAST);

    radix4_booth_mult #(.W(W)) u_mult (
        .a (a_reg[cnt*W +: W]),
        .b (b_reg[cnt*W +: W]),
        .p (prod)
    );

`ifdef INNER_PRODUCT_PIPE_EN
    logic signed [2*W-1:0] prod_q;
    assign prod_ext = PW'(prod_q);
`else
    assign prod_ext = PW'(prod);
`endif

    assign acc_sum = acc + prod_ext;

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
`ifdef INNER_PRODUCT_PIPE_EN
                if (last) state_next = DRAIN;
`else
                if (last) state_next = DONE;
`endif
            end
`ifdef INNER_PRODUCT_PIPE_EN
            DRAIN: begin
                busy       = 1'b1;
                state_next = DONE;
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: operand registers take no reset; they are always reloaded on acceptance before being read.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_reg <= a;
            b_reg <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            p      <= '0;
`ifdef INNER_PRODUCT_PIPE_EN
            prod_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt    <= '0;
                        acc    <= '0;
`ifdef INNER_PRODUCT_PIPE_EN
                        prod_q <= '0;
`endif
                    end
                end
                RUN: begin
                    acc <= acc_sum;
                    cnt <= last ? '0 : cnt + 1'b1;
`ifdef INNER_PRODUCT_PIPE_EN
                    prod_q <= prod;
`else
                    if (last) p <= acc_sum;
`endif
                end
`ifdef INNER_PRODUCT_PIPE_EN
                // Product register still holds the final element's product.
                DRAIN: p <= acc_sum;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inner_product_seq.sv
// Directed and randomised self-checking bench for inner_product_seq (N=3/W=8, N=1/W=4, N=5/W=8).
// Latency expectations follow INNER_PRODUCT_PIPE_EN when it is defined.
module tb_inner_product_seq;

`ifdef INNER_PRODUCT_PIPE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // N=3, W=8, PW=18
    logic               in_valid3 = 1'b0, out_ready3 = 1'b1;
    logic               in_ready3, out_valid3, busy3;
    logic [23:0]        a3 = '0, b3 = '0;
    logic signed [17:0] p3;

    // N=1, W=4, PW=8
    logic               in_valid1 = 1'b0, out_ready1 = 1'b1;
    logic               in_ready1, out_valid1, busy1;
    logic [3:0]         a1 = '0, b1 = '0;
    logic signed [7:0]  p1;

    // N=5, W=8, PW=19
    logic               in_valid5 = 1'b0, out_ready5 = 1'b0;
    logic               in_ready5, out_valid5, busy5;
    logic [39:0]        a5 = '0, b5 = '0;
    logic signed [18:0] p5;

    logic [39:0]        av5, bv5;
    logic signed [63:0] ref5;
    int                 cyc;

    inner_product_seq #(.W(8), .N(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .a(a3), .b(b3),
        .out_valid(out_valid3), .out_ready(out_ready3), .p(p3), .busy(busy3)
    );

    inner_product_seq #(.W(4), .N(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1), .p(p1), .busy(busy1)
    );

    inner_product_seq #(.W(8), .N(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .a(a5), .b(b5),
        .out_valid(out_valid5), .out_ready(out_ready5), .p(p5), .busy(busy5)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pack3(input int e0, input int e1, input int e2);
        return {8'(e2), 8'(e1), 8'(e0)};
    endfunction

    // Called at a negedge with dut3 idle; returns at the first negedge where out_valid3 is high.
    task automatic run3(input logic [23:0] av, input logic [23:0] bv, input string tag,
                        input logic signed [63:0] exp_p);
        int c;
        check({tag, " in_ready before"}, in_ready3, 1);
        in_valid3 = 1'b1;
        a3 = av;
        b3 = bv;
        @(negedge clk);
        in_valid3 = 1'b0;
        a3 = ~av;
        b3 = 24'h5a5a5a;
        check({tag, " busy"}, busy3, 1);
        c = 0;
        while (!out_valid3 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check({tag, " latency"}, c, 3 + EXTRA);
        check({tag, " p"}, p3, exp_p);
    endtask

    // Handshake with out_ready3=1 happens on the next edge; dut3 must then be idle again.
    task automatic handshake3(input string tag, input logic signed [63:0] exp_p);
        out_ready3 = 1'b1;
        @(negedge clk);
        check({tag, " out_valid after hs"}, out_valid3, 0);
        check({tag, " in_ready after hs"}, in_ready3, 1);
        check({tag, " p held"}, p3, exp_p);
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        check("rst in_ready3", in_ready3, 1);
        check("rst out_valid3", out_valid3, 0);
        check("rst p3", p3, 0);
        check("rst busy3", busy3, 0);
        check("rst in_ready1", in_ready1, 1);
        check("rst busy1", busy1, 0);
        check("rst in_ready5", in_ready5, 1);
        check("rst busy5", busy5, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic: 3 * 15 * 15
        run3(pack3(15, 15, 15), pack3(15, 15, 15), "basic", 675);
        check("basic in_ready in DONE", in_ready3, 0);
        handshake3("basic", 675);

        // Most negative operands
        run3(pack3(-128, -128, -128), pack3(-128, -128, -128), "negneg", 49152);
        handshake3("negneg", 49152);
        run3(pack3(-128, -128, -128), pack3(127, 127, 127), "negpos", -48768);
        handshake3("negpos", -48768);

        // Backpressure: 10*2 + (-3)*4 + 7*(-5) = -27
        out_ready3 = 1'b0;
        run3(pack3(10, -3, 7), pack3(2, 4, -5), "bp", -27);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                in_valid3 = 1'b1;
                a3 = pack3(1, 1, 1);
                b3 = pack3(1, 1, 1);
            end
            @(negedge clk);
            in_valid3 = 1'b0;
            check("bp out_valid held", out_valid3, 1);
            check("bp in_ready held", in_ready3, 0);
            check("bp p held", p3, -27);
        end
        handshake3("bp", -27);
        out_ready3 = 1'b0;
        @(negedge clk);
        check("bp no second result", out_valid3, 0);
        check("bp pulse ignored", busy3, 0);
        out_ready3 = 1'b1;

        // Reset during the second RUN cycle
        in_valid3 = 1'b1;
        a3 = pack3(1, 2, 3);
        b3 = pack3(4, 5, 6);
        @(negedge clk);
        in_valid3 = 1'b0;
        check("midrst busy", busy3, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst out_valid", out_valid3, 0);
        check("midrst p", p3, 0);
        check("midrst in_ready", in_ready3, 1);
        check("midrst busy idle", busy3, 0);
        run3(pack3(1, 2, 3), pack3(4, 5, 6), "after rst", 32);
        handshake3("after rst", 32);

        // N=1, W=4: (-8)*(-8)
        check("n1 in_ready", in_ready1, 1);
        in_valid1 = 1'b1;
        a1 = 4'h8;
        b1 = 4'h8;
        @(negedge clk);
        in_valid1 = 1'b0;
        a1 = 4'h3;
        b1 = 4'h5;
        cyc = 0;
        while (!out_valid1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("n1 latency", cyc, 1 + EXTRA);
        check("n1 p", p1, 64);
        @(negedge clk);
        check("n1 in_ready after hs", in_ready1, 1);

        // N=5 random regression with idle gaps, stray in_valid and out_ready backpressure
        for (int v = 0; v < 1000; v++) begin
            av5 = 40'({$urandom(), $urandom()});
            bv5 = 40'({$urandom(), $urandom()});
            if (v % 97 == 0) begin
                av5 = {5{8'h80}};
                bv5 = (v % 2 == 0) ? {5{8'h80}} : {5{8'h7f}};
            end
            ref5 = 0;
            for (int i = 0; i < 5; i++) begin
                ref5 += longint'($signed(av5[i*8 +: 8])) * longint'($signed(bv5[i*8 +: 8]));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            in_valid5 = 1'b1;
            a5 = av5;
            b5 = bv5;
            @(negedge clk);
            in_valid5 = 1'b0;
            cyc = 0;
            while (!out_valid5 && cyc < 40) begin
                in_valid5 = 1'($urandom_range(0, 1));
                a5 = 40'({$urandom(), $urandom()});
                b5 = 40'({$urandom(), $urandom()});
                @(negedge clk);
                cyc++;
            end
            in_valid5 = 1'b0;
            check("rand latency", cyc, 5 + EXTRA);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("rand p", p5, ref5);
            out_ready5 = 1'b1;
            @(negedge clk);
            out_ready5 = 1'b0;
        end
        check("rand idle at end", in_ready5, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inner_product_seq.md
Name: inner_product_seq

Overview:
- Parametrised sequential successor to the three-element combinational inner product.
- Computes the dot product of two N-element vectors of signed W-bit operands through a single radix-4 Booth multiplier, one element pair per cycle.
- Uses a valid/ready handshake on both input and output.
- Sits between an operand source (vector registers or FIFO) and a result consumer in the DSP datapath.

Parameters:
- W, 8, operand width in bits, two's complement; W >= 2, even.
- N, 3, number of elements per vector; N >= 1.
- PW, 2*W + $clog2(N) (derived localparam, not overridable), result width; can never overflow.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand vectors a and b are valid.
- in_ready  out  1  block can accept a new vector pair.
- a  in  N*W  vector A; element i occupies a[i*W +: W].
- b  in  N*W  vector B; element i occupies b[i*W +: W].
- out_valid  out  1  p holds a completed result.
- out_ready  in  1  consumer accepts p.
- p  out  PW  signed inner product, sum over i of a[i]*b[i].
- busy  out  1  high in RUN (and DRAIN when present).

Behaviour:
- Reset (rst=1 at a clock edge, in any state):
  - state=IDLE, in_ready=1, out_valid=0, p=0, busy=0, element counter=0, accumulator=0.
  - Captured operands are discarded.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready at an edge (E0): latch a and b into internal registers, clear the accumulator, set counter=0, go to RUN.
  - a and b may change after E0.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: acc <= acc + sext(a_reg[cnt]*b_reg[cnt]); cnt <= cnt+1.
  - The product is the full signed 2W-bit value from the multiplier, sign-extended to PW.
  - On the edge where cnt==N-1: go to DONE; p <= final sum; out_valid <= 1.
  - Latency: out_valid is high N cycles after the acceptance edge E0.
  - N=1: RUN lasts exactly one edge.
- DONE:
  - out_valid=1; p is held stable; in_ready=0.
  - When out_valid&&out_ready at an edge: out_valid <= 0, go to IDLE. p keeps its last value (not cleared).
  - out_ready low holds DONE indefinitely.
  - Throughput: one vector per N+2 cycles; the IDLE bubble is mandatory because in_ready is not asserted in DONE.
- in_valid outside IDLE is ignored. out_ready outside DONE is ignored.
- Counter wraps to 0 on exit from RUN. No state encodings beyond those listed; any illegal state returns to IDLE on the next edge.
- Arithmetic:
  - Operands are signed two's complement.
  - The most negative operands are exact: (-2^(W-1))^2 = 2^(2W-2) fits in 2W signed bits.
  - The accumulator is PW bits and needs no saturation.

Optional Feature:
- Macro: INNER_PRODUCT_PIPE_EN.
- Defined:
  - A register is inserted between the multiplier output and the accumulator.
  - An extra DRAIN state follows RUN for one cycle to add the last product.
  - Latency becomes N+1 cycles from E0; throughput is one vector per N+3 cycles; busy is high in DRAIN.
  - Reset also clears the product register.
- Undefined: combinational multiply-accumulate in one cycle as described above; no DRAIN state.
- Results are identical in both builds; only timing differs.

Decomposition:
- Package inner_product_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - function clog2_min1 for the counter width, max(1, $clog2(N));
  - result-width helper.
- Sub-module radix4_booth_mult:
  - parameter W; combinational signed W×W -> 2W;
  - radix-4 Booth recoding and partial-product sum.
- Instantiated once.

Test Plan:
- W=8, N=3, a={15,15,15}, b={15,15,15}, out_ready=1:
  - p=675.
  - out_valid high exactly 3 cycles after E0 (4 with PIPE_EN).
  - in_ready returns high the cycle after the output handshake.
- Extremes: all a=-128, all b=-128 -> p=49152. All a=-128, all b=127 -> p=-48768 (18-bit two's complement).
- Backpressure: out_ready=0 for 10 cycles in DONE:
  - p and out_valid stay stable; in_ready stays 0.
  - A new in_valid pulse is ignored.
  - Release out_ready -> single handshake, then IDLE.
- Reset mid-RUN: assert rst at the second RUN cycle of a={1,2,3}, b={4,5,6}:
  - Next cycle: out_valid=0, p=0, in_ready=1.
  - Next vector a={1,2,3}, b={4,5,6} -> p=32 with no residue.
- N=1, W=4: a=-8, b=-8 -> p=64 in PW=8 bits, one cycle after E0.
- Random regression, N=5, W=8: 1000 vectors with random in_valid/out_ready gaps; compare against a reference sum; run both with and without INNER_PRODUCT_PIPE_EN.
